// File: rtl/pio_pkg.sv
// Shared PIO definitions: command action codes, config-entry layout and loader FSM states.
package pio_pkg;

    localparam logic [3:0] ACT_NONE    = 4'd0;
    localparam logic [3:0] ACT_INSTR   = 4'd1;
    localparam logic [3:0] ACT_WRAP    = 4'd2;
    localparam logic [3:0] ACT_PINS    = 4'd5;
    localparam logic [3:0] ACT_ENABLE  = 4'd6;
    localparam logic [3:0] ACT_DIVIDER = 4'd7;
    localparam logic [3:0] ACT_SIDESET = 4'd8;

    // Config entry: {mindex[1:0], action[3:0], data[31:0]}
    localparam int CFG_W        = 38;
    localparam int CFG_DATA_LSB = 0;
    localparam int CFG_DATA_W   = 32;
    localparam int CFG_ACT_LSB  = 32;
    localparam int CFG_ACT_W    = 4;
    localparam int CFG_MIDX_LSB = 36;
    localparam int CFG_MIDX_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROG = 2'd1,
        S_CFG  = 2'd2,
        S_FIN  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/pio_loader.sv
// Streams a program ROM into PIO instruction memory, then replays a config ROM as PIO commands.
// Commands are emitted one cycle after each ROM address, straight from the ROM read data.
module pio_loader
    import pio_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int CFG_DEPTH  = 32,
    parameter int NUM_SM     = 4
) (
    input  logic                                        clk_25mhz,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [$clog2(PROG_DEPTH):0]                 plen,
    input  logic [$clog2(CFG_DEPTH):0]                  clen,
    output logic [$clog2(PROG_DEPTH)-1:0]               prog_addr,
    input  logic [15:0]                                 prog_data,
    output logic [$clog2(CFG_DEPTH)-1:0]                cfg_addr,
    input  logic [37:0]                                 cfg_data,
    output logic [3:0]                                  action,
    output logic [31:0]                                 din,
    output logic [$clog2(PROG_DEPTH)-1:0]               index,
    output logic [(NUM_SM > 1 ? $clog2(NUM_SM) : 1)-1:0] mindex,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic [1:0]                                  state_dbg
);

    localparam int AW  = $clog2(PROG_DEPTH);
    localparam int CW  = $clog2(CFG_DEPTH);
    localparam int PLW = AW + 1;
    localparam int CLW = CW + 1;
    localparam int MW  = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    ld_state_e      state, state_nx;
    logic [PLW-1:0] plen_q, prog_cnt;
    logic [CLW-1:0] clen_q, cfg_cnt;
    logic [AW-1:0]  idx_q;
    logic           p_vld, c_vld;
    logic           prog_rd, cfg_rd;
    logic           len_ok, accept, reject;
    logic           prog_last, cfg_last;

    logic [CFG_ACT_W-1:0]  cfg_act;
    logic [CFG_MIDX_W-1:0] cfg_midx;
    logic [CFG_DATA_W-1:0] cfg_payload;

    assign len_ok    = (plen <= PLW'(PROG_DEPTH)) && (clen <= CLW'(CFG_DEPTH));
    assign accept    = (state == S_IDLE) && start && len_ok;
    assign reject    = (state == S_IDLE) && start && !len_ok;
    assign prog_last = (prog_cnt == plen_q - PLW'(1));
    assign cfg_last  = (cfg_cnt == clen_q - CLW'(1));

    always_ff @(posedge clk_25mhz) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (plen != '0)      state_nx = S_PROG;
                    else if (clen != '0) state_nx = S_CFG;
                    else                 state_nx = S_FIN;
                end
            end
            S_PROG: begin
                if (prog_last) state_nx = (clen_q != '0) ? S_CFG : S_FIN;
            end
            S_CFG: begin
                if (cfg_last) state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        prog_rd = 1'b0;
        cfg_rd  = 1'b0;
        case (state)
            S_PROG:  prog_rd = 1'b1;
            S_CFG:   cfg_rd  = 1'b1;
            default: ;
        endcase
    end

    // Counters hold on their last address instead of stepping past the end.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            plen_q   <= '0;
            clen_q   <= '0;
            prog_cnt <= '0;
            cfg_cnt  <= '0;
            idx_q    <= '0;
            p_vld    <= 1'b0;
            c_vld    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            p_vld <= prog_rd;
            c_vld <= cfg_rd;
            busy  <= (state_nx != S_IDLE);
            if (prog_rd) begin
                idx_q <= prog_cnt[AW-1:0];
                if (!prog_last) prog_cnt <= prog_cnt + PLW'(1);
            end
            if (cfg_rd && !cfg_last) cfg_cnt <= cfg_cnt + CLW'(1);
            if (accept) begin
                plen_q   <= plen;
                clen_q   <= clen;
                prog_cnt <= '0;
                cfg_cnt  <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
            end
            if (reject) begin
                err  <= 1'b1;
                done <= 1'b0;
            end
            if (state == S_FIN) done <= 1'b1;
        end
    end

    assign cfg_act     = cfg_data[CFG_ACT_LSB +: CFG_ACT_W];
    assign cfg_midx    = cfg_data[CFG_MIDX_LSB +: CFG_MIDX_W];
    assign cfg_payload = cfg_data[CFG_DATA_LSB +: CFG_DATA_W];

    always_comb begin
        action = ACT_NONE;
        din    = '0;
        mindex = '0;
        if (p_vld) begin
            action = ACT_INSTR;
            din    = {16'h0, prog_data};
        end else if (c_vld) begin
            action = cfg_act;
            din    = cfg_payload;
            mindex = MW'(cfg_midx);
        end
    end

    assign index     = idx_q;
    assign prog_addr = prog_cnt[AW-1:0];
    assign cfg_addr  = cfg_cnt[CW-1:0];
    assign state_dbg = state;

endmodule
